// File: rtl/llfifo_cmd_sched.sv
// Command scheduler in front of the multi-queue linked-list FIFO controller.
// Arbitrates per-queue push/pop requests, issues at most one controller
// command every two cycles, and owns the payload array addressed by the
// controller's pointers.
module llfifo_cmd_sched #(
    parameter int unsigned ID_N  = 4,
    parameter int unsigned PTR_N = 16,
    parameter int unsigned W     = 32,
    localparam int unsigned IW   = (ID_N  > 1) ? $clog2(ID_N)  : 1,
    localparam int unsigned PW   = (PTR_N > 1) ? $clog2(PTR_N) : 1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            push_vld,
    input  logic [IW-1:0]   push_id,
    input  logic [W-1:0]    push_dat,
    output logic            push_rdy,

    input  logic            pop_vld,
    input  logic [IW-1:0]   pop_id,
    output logic            pop_rdy,

    output logic            pop_rsp_vld,
    output logic [IW-1:0]   pop_rsp_id,
    output logic [W-1:0]    pop_rsp_dat,
    output logic            pop_rsp_err,

    input  logic            flush,

    output logic            cmd_pass,
    output logic            cmd_push,
    output logic [IW-1:0]   cmd_id,
    output logic            clear,

    input  logic [PW-1:0]   cmd_push_ptr_r,
    input  logic [PW-1:0]   cmd_pop_ptr_w,
    input  logic            full_r,
    input  logic [ID_N-1:0] nempty_r,
    input  logic            busy_r
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   prio_q;
    logic   prio_d;

    logic   can_issue_c;
    logic   push_elig_c;
    logic   pop_elig_c;
    logic   grant_push_c;
    logic   grant_pop_c;
    logic   issue_c;
    logic   pop_hit_c;

    logic [W-1:0] mem [PTR_N];
    logic [W-1:0] rd_dat_c;

    // Issue slot and arbitration terms; prio_q=0 favours push on contention.
    assign can_issue_c  = (state_q == ST_IDLE) & ~busy_r & ~flush & ~rst;
    assign push_elig_c  = push_vld & ~full_r;
    assign pop_elig_c   = pop_vld;
    assign grant_push_c = push_elig_c & (~pop_elig_c | ~prio_q);
    assign grant_pop_c  = pop_elig_c & (~push_elig_c | prio_q);
    assign issue_c      = can_issue_c & (grant_push_c | grant_pop_c);
    assign pop_hit_c    = pop_rdy & nempty_r[pop_id];

    assign clear    = flush;
    assign rd_dat_c = mem[cmd_pop_ptr_w];

    // State and priority registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Next state: every issue (including error pops) costs one WAIT cycle so
    // the controller's status flags are settled in each IDLE cycle.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (flush) begin
            state_d = ST_IDLE;
            prio_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (issue_c) state_d = ST_WAIT;
                ST_WAIT: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            if (issue_c & push_elig_c & pop_elig_c) begin
                prio_d = ~prio_q;
            end
        end
    end

    // Handshake and controller command outputs; an empty-queue pop is
    // accepted but never reaches the controller.
    always_comb begin
        push_rdy = 1'b0;
        pop_rdy  = 1'b0;
        cmd_pass = 1'b0;
        cmd_push = 1'b0;
        cmd_id   = pop_id;
        if (can_issue_c) begin
            if (grant_push_c) begin
                push_rdy = 1'b1;
                cmd_pass = 1'b1;
                cmd_push = 1'b1;
                cmd_id   = push_id;
            end else if (grant_pop_c) begin
                pop_rdy  = 1'b1;
                cmd_pass = nempty_r[pop_id];
            end
        end
    end

    // Payload storage, written at the free entry the controller offers.
    always_ff @(posedge clk) begin
        if (push_rdy) begin
            mem[cmd_push_ptr_r] <= push_dat;
        end
    end

    // Pop response, one cycle after the grant; data is zero on error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_rsp_vld <= 1'b0;
            pop_rsp_id  <= '0;
            pop_rsp_dat <= '0;
            pop_rsp_err <= 1'b0;
        end else begin
            pop_rsp_vld <= pop_rdy;
            if (pop_rdy) begin
                pop_rsp_id  <= pop_id;
                pop_rsp_dat <= pop_hit_c ? rd_dat_c : '0;
                pop_rsp_err <= ~pop_hit_c;
            end
        end
    end

endmodule

// File: tb/tb_llfifo_cmd_sched.sv
// Bench for llfifo_cmd_sched: a queue-based stand-in for the linked-list
// controller, a per-cycle scoreboard of the scheduling rules, and directed
// scenarios with literal expectations.
module tb_llfifo_cmd_sched;

    localparam int unsigned ID_N  = 4;
    localparam int unsigned PTR_N = 16;
    localparam int unsigned W     = 32;
    localparam int unsigned IW    = 2;
    localparam int unsigned PW    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            push_vld;
    logic [IW-1:0]   push_id;
    logic [W-1:0]    push_dat;
    logic            push_rdy;
    logic            pop_vld;
    logic [IW-1:0]   pop_id;
    logic            pop_rdy;
    logic            pop_rsp_vld;
    logic [IW-1:0]   pop_rsp_id;
    logic [W-1:0]    pop_rsp_dat;
    logic            pop_rsp_err;
    logic            flush;
    logic            cmd_pass;
    logic            cmd_push;
    logic [IW-1:0]   cmd_id;
    logic            clear;
    logic [PW-1:0]   cmd_push_ptr_r;
    logic [PW-1:0]   cmd_pop_ptr_w;
    logic            full_r;
    logic [ID_N-1:0] nempty_r;
    logic            busy_r;

    int n_checks = 0;
    int n_pass   = 0;
    bit busy_hold = 1'b0;

    llfifo_cmd_sched #(.ID_N(ID_N), .PTR_N(PTR_N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .push_vld(push_vld), .push_id(push_id), .push_dat(push_dat), .push_rdy(push_rdy),
        .pop_vld(pop_vld), .pop_id(pop_id), .pop_rdy(pop_rdy),
        .pop_rsp_vld(pop_rsp_vld), .pop_rsp_id(pop_rsp_id),
        .pop_rsp_dat(pop_rsp_dat), .pop_rsp_err(pop_rsp_err),
        .flush(flush),
        .cmd_pass(cmd_pass), .cmd_push(cmd_push), .cmd_id(cmd_id), .clear(clear),
        .cmd_push_ptr_r(cmd_push_ptr_r), .cmd_pop_ptr_w(cmd_pop_ptr_w),
        .full_r(full_r), .nempty_r(nempty_r), .busy_r(busy_r)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        $display("FAIL %s: no handshake within cycle bound", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Controller stand-in: free pointer list plus one pointer queue per id.
    int            free_l [$];
    int            ll [ID_N][$];
    logic [PW-1:0] head_arr [ID_N];

    always @(posedge clk or posedge rst) begin : ctrl_model
        int p;
        if (rst || clear) begin
            free_l.delete();
            for (int i = 0; i < int'(PTR_N); i++) free_l.push_back(i);
            for (int q = 0; q < int'(ID_N); q++) ll[q].delete();
            busy_r <= 1'b0;
        end else begin
            if (cmd_pass) begin
                if (cmd_push) begin
                    if (free_l.size() > 0) begin
                        p = free_l.pop_front();
                        ll[cmd_id].push_back(p);
                    end
                end else if (ll[cmd_id].size() > 0) begin
                    p = ll[cmd_id].pop_front();
                    free_l.push_back(p);
                end
            end
            busy_r <= cmd_pass | busy_hold;
        end
        cmd_push_ptr_r <= (free_l.size() > 0) ? PW'(free_l[0]) : '0;
        full_r         <= (free_l.size() == 0);
        for (int q = 0; q < int'(ID_N); q++) begin
            head_arr[q] <= (ll[q].size() > 0) ? PW'(ll[q][0]) : '0;
            nempty_r[q] <= (ll[q].size() > 0);
        end
    end

    assign cmd_pop_ptr_w = head_arr[cmd_id];

    // Scoreboard: data queues per id, one-issue-per-two-cycles rule,
    // alternating priority on contention, one-cycle pop response.
    logic [W-1:0] exp_q [ID_N][$];
    bit           issued_prev = 1'b0;
    bit           prio_m = 1'b0;
    bit           rsp_v = 1'b0;
    bit           rsp_e = 1'b0;
    logic [IW-1:0] rsp_id = '0;
    logic [W-1:0]  rsp_d = '0;

    always @(negedge clk) begin : model_cmp
        bit can, pe, po, gp, go, epr, eor, hit, epass;
        int total;
        if (rst) begin
            chk("rst_push_rdy", push_rdy, 0);
            chk("rst_pop_rdy", pop_rdy, 0);
            chk("rst_cmd_pass", cmd_pass, 0);
            chk("rst_rsp_vld", pop_rsp_vld, 0);
            chk("rst_rsp_id", pop_rsp_id, 0);
            chk("rst_rsp_dat", pop_rsp_dat, 0);
            chk("rst_rsp_err", pop_rsp_err, 0);
            issued_prev = 1'b0;
            prio_m      = 1'b0;
            rsp_v       = 1'b0;
            for (int q = 0; q < int'(ID_N); q++) exp_q[q].delete();
        end else begin
            total = 0;
            for (int q = 0; q < int'(ID_N); q++) total += exp_q[q].size();
            can   = !issued_prev && !busy_r && !flush;
            pe    = push_vld && (total < int'(PTR_N));
            po    = pop_vld;
            gp    = pe && (!po || !prio_m);
            go    = po && (!pe || prio_m);
            epr   = can && gp;
            eor   = can && go;
            hit   = eor && (exp_q[pop_id].size() > 0);
            epass = epr || hit;

            chk("clear", clear, flush);
            chk("push_rdy", push_rdy, epr);
            chk("pop_rdy", pop_rdy, eor);
            chk("cmd_pass", cmd_pass, epass);
            if (epass) begin
                chk("cmd_push", cmd_push, epr);
                chk("cmd_id", cmd_id, epr ? push_id : pop_id);
            end
            chk("rsp_vld", pop_rsp_vld, rsp_v);
            if (rsp_v) begin
                chk("rsp_id", pop_rsp_id, rsp_id);
                chk("rsp_dat", pop_rsp_dat, rsp_d);
                chk("rsp_err", pop_rsp_err, rsp_e);
            end

            rsp_v = eor;
            if (eor) begin
                rsp_id = pop_id;
                if (hit) begin
                    rsp_d = exp_q[pop_id].pop_front();
                    rsp_e = 1'b0;
                end else begin
                    rsp_d = '0;
                    rsp_e = 1'b1;
                end
            end
            if (epr) exp_q[push_id].push_back(push_dat);
            if (flush) for (int q = 0; q < int'(ID_N); q++) exp_q[q].delete();
            issued_prev = epr || eor;
            if (flush) prio_m = 1'b0;
            else if (can && pe && po) prio_m = ~prio_m;
        end
    end

    task automatic do_push(input logic [IW-1:0] id, input logic [W-1:0] d);
        bit ok = 1'b0;
        push_vld = 1'b1;
        push_id  = id;
        push_dat = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (push_rdy) begin
                ok = 1'b1;
                chk("push_cmd_pass", cmd_pass, 1);
            end
            tick();
        end
        push_vld = 1'b0;
        if (!ok) timeout("push_accept");
    endtask

    task automatic do_pop(input logic [IW-1:0] id, input logic [W-1:0] edat, input logic eerr);
        bit ok = 1'b0;
        pop_vld = 1'b1;
        pop_id  = id;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (pop_rdy) ok = 1'b1;
            tick();
        end
        pop_vld = 1'b0;
        if (!ok) timeout("pop_accept");
        else begin
            @(negedge clk);
            chk("pop_rsp_vld_next", pop_rsp_vld, 1);
            chk("pop_rsp_dat_lit", pop_rsp_dat, edat);
            chk("pop_rsp_err_lit", pop_rsp_err, eerr);
        end
    endtask

    initial begin : stim
        int k, npush, npass, consec, ng;
        bit prev, g_push, g_pop;
        logic [3:0] seq;

        rst = 1'b1; push_vld = 1'b1; push_id = '0; push_dat = 32'hDEAD;
        pop_vld = 1'b0; pop_id = '0; flush = 1'b0;

        // Reset: ready held low even with a valid request.
        @(negedge clk);
        chk("reset_push_rdy", push_rdy, 0);
        chk("reset_rsp_vld", pop_rsp_vld, 0);
        @(negedge clk);
        tick();
        rst = 1'b0; push_vld = 1'b0;
        repeat (2) tick();

        // Ordering on one queue.
        do_push(2'd2, 32'hA1);
        do_push(2'd2, 32'hA2);
        do_push(2'd2, 32'hA3);
        do_pop(2'd2, 32'hA1, 1'b0);
        do_pop(2'd2, 32'hA2, 1'b0);
        do_pop(2'd2, 32'hA3, 1'b0);
        chk("nempty2_after_drain", nempty_r[2], 0);
        repeat (2) tick();

        // Throughput: held push_vld yields an accept every other cycle.
        k = 0; npush = 0; npass = 0; consec = 0; prev = 1'b0;
        push_vld = 1'b1; push_id = '0; push_dat = 32'h100;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (push_rdy) npush++;
            if (cmd_pass) npass++;
            if (push_rdy && prev) consec++;
            prev = push_rdy;
            tick();
            if (prev) begin
                k++;
                push_id  = IW'(k % 4);
                push_dat = 32'h100 + 32'(k);
            end
        end
        push_vld = 1'b0;
        chk("thru_push_count", 32'(npush), 8);
        chk("thru_pass_count", 32'(npass), 8);
        chk("thru_back_to_back", 32'(consec), 0);
        for (int q = 0; q < 4; q++) begin
            do_pop(IW'(q), 32'h100 + 32'(q), 1'b0);
            do_pop(IW'(q), 32'h104 + 32'(q), 1'b0);
        end
        repeat (2) tick();

        // Full: stall the 17th push, serve a pop, then accept two cycles later.
        for (int i = 0; i < 16; i++) do_push(2'd0, 32'h200 + 32'(i));
        push_vld = 1'b1; push_id = 2'd1; push_dat = 32'h2FF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("full_stall", push_rdy, 0);
            tick();
        end
        pop_vld = 1'b1; pop_id = 2'd0;
        @(negedge clk);
        chk("full_pop_rdy", pop_rdy, 1);
        chk("full_push_blocked", push_rdy, 0);
        tick();
        pop_vld = 1'b0;
        @(negedge clk);
        chk("full_wait_push", push_rdy, 0);
        chk("full_pop_rsp", pop_rsp_dat, 32'h200);
        tick();
        @(negedge clk);
        chk("full_stalled_accept", push_rdy, 1);
        tick();
        push_vld = 1'b0;
        repeat (2) tick();

        // Flush in WAIT with a response pending, then IDLE next cycle.
        pop_vld = 1'b1; pop_id = 2'd0;
        @(negedge clk);
        chk("flush_pre_pop_rdy", pop_rdy, 1);
        tick();
        flush = 1'b1; push_vld = 1'b1; push_id = 2'd2; push_dat = 32'h3AA; pop_id = 2'd1;
        @(negedge clk);
        chk("flush_clear", clear, 1);
        chk("flush_no_push", push_rdy, 0);
        chk("flush_no_pop", pop_rdy, 0);
        chk("flush_rsp_vld", pop_rsp_vld, 1);
        chk("flush_rsp_dat", pop_rsp_dat, 32'h201);
        tick();
        flush = 1'b0; push_vld = 1'b0;
        @(negedge clk);
        chk("flush_idle_pop", pop_rdy, 1);
        chk("flush_cleared_q", cmd_pass, 0);
        tick();
        pop_vld = 1'b0;
        @(negedge clk);
        chk("flush_err", pop_rsp_err, 1);
        repeat (2) tick();

        // Empty pop.
        pop_vld = 1'b1; pop_id = 2'd3;
        @(negedge clk);
        chk("empty_pop_rdy", pop_rdy, 1);
        chk("empty_no_cmd", cmd_pass, 0);
        tick();
        pop_vld = 1'b0;
        @(negedge clk);
        chk("empty_rsp_vld", pop_rsp_vld, 1);
        chk("empty_rsp_err", pop_rsp_err, 1);
        chk("empty_rsp_dat", pop_rsp_dat, 0);
        chk("empty_rsp_id", pop_rsp_id, 3);
        repeat (2) tick();

        // Contention: grants alternate push, pop, push, pop.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        k = 0; ng = 0; seq = '0;
        push_vld = 1'b1; push_id = 2'd1; push_dat = 32'h300;
        pop_vld = 1'b1; pop_id = 2'd1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            g_push = push_rdy;
            g_pop  = pop_rdy;
            if (g_push || g_pop) begin
                seq = {seq[2:0], g_push};
                ng++;
            end
            tick();
            if (g_push) begin
                k++;
                push_dat = 32'h300 + 32'(k);
            end
        end
        push_vld = 1'b0; pop_vld = 1'b0;
        chk("contention_seq", 32'(seq), 32'b1010);
        chk("contention_grants", 32'(ng), 4);
        repeat (2) tick();

        // busy_r blocks issue in IDLE.
        busy_hold = 1'b1;
        tick();
        push_vld = 1'b1; push_id = 2'd0; push_dat = 32'h400;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("busy_block", push_rdy, 0);
            tick();
        end
        busy_hold = 1'b0;
        do_push(2'd0, 32'h400);
        repeat (2) tick();

        // Asynchronous reset during a pending response.
        pop_vld = 1'b1; pop_id = 2'd0;
        @(negedge clk);
        chk("rst_mid_pop_rdy", pop_rdy, 1);
        tick();
        pop_vld = 1'b0; push_vld = 1'b1; push_id = 2'd2; push_dat = 32'h500;
        #1;
        chk("rst_mid_rsp_before", pop_rsp_dat, 32'h400);
        rst = 1'b1;
        #1;
        chk("rst_async_vld", pop_rsp_vld, 0);
        chk("rst_async_dat", pop_rsp_dat, 0);
        chk("rst_async_push_rdy", push_rdy, 0);
        chk("rst_async_cmd_pass", cmd_pass, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; push_vld = 1'b0;
        repeat (2) tick();

        do_push(2'd1, 32'h600);
        do_pop(2'd1, 32'h600, 1'b0);
        do_pop(2'd1, 32'h0, 1'b1);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/llfifo_cmd_sched.md
Name: llfifo_cmd_sched

Overview:
- Upstream front-end of linked_list_fifo_cntrl; together they form the multi-queue linked-list FIFO.
- Accepts per-queue push and pop requests on valid/ready ports and arbitrates between them.
- Drives cmd_pass, cmd_push and cmd_id into the controller.
- Owns the payload storage array, indexed by the controller's pointers, and returns popped data one cycle after issue.

Parameters:
- ID_N, 4, number of logical queues; id width IW = $clog2(ID_N).
- PTR_N, 16, number of linked-list entries (must match controller); pointer width PW = $clog2(PTR_N).
- W, 32, payload width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- push_vld  in  1  push request.
- push_id  in  IW  target queue.
- push_dat  in  W  payload.
- push_rdy  out  1  push accepted this cycle when push_vld is also high.
- pop_vld  in  1  pop request.
- pop_id  in  IW  source queue.
- pop_rdy  out  1  pop accepted this cycle when pop_vld is also high.
- pop_rsp_vld  out  1  pop response strobe.
- pop_rsp_id  out  IW  queue of the response.
- pop_rsp_dat  out  W  popped payload; 0 on error.
- pop_rsp_err  out  1  pop targeted an empty queue.
- flush  in  1  clear all queues.
- cmd_pass  out  1  command to controller.
- cmd_push  out  1  1 = push, 0 = pop.
- cmd_id  out  IW  command queue id.
- clear  out  1  clear to controller; equals flush.
- cmd_push_ptr_r  in  PW  free entry for the next push.
- cmd_pop_ptr_w  in  PW  head entry of queue cmd_id.
- full_r  in  1  controller full.
- nempty_r  in  ID_N  per-queue non-empty flags.
- busy_r  in  1  controller update in flight.

Behaviour:
- FSM states:
  - IDLE: may issue.
  - WAIT: one cycle, no issue.
  - IDLE->WAIT on any issue (push or pop, including error pops); WAIT->IDLE unconditionally.
  - Result: at most one command per 2 cycles, which guarantees full_r, nempty_r and busy_r are current in every IDLE cycle.
- can_issue = (state==IDLE) & !busy_r & !flush & !rst.
- Eligibility:
  - push_elig = push_vld & !full_r.
  - pop_elig = pop_vld; pop eligibility does not depend on nempty_r.
- Arbitration, 1-bit prio register (0 favours push):
  - If both eligible, grant the favoured one, then toggle prio.
  - If only one is eligible, grant it; prio is unchanged.
- push_rdy = can_issue & push grant; pop_rdy = can_issue & pop grant. Ready may depend combinationally on the other port's valid.
- Push grant, cycle t:
  - cmd_pass=1, cmd_push=1, cmd_id=push_id.
  - mem[cmd_push_ptr_r] <= push_dat at the end of t.
- Pop grant with nempty_r[pop_id]=1, cycle t:
  - cmd_pass=1, cmd_push=0, cmd_id=pop_id.
  - Read mem[cmd_pop_ptr_w] in t.
  - Cycle t+1: pop_rsp_vld=1, pop_rsp_id=pop_id, pop_rsp_dat=that word, pop_rsp_err=0.
- Pop grant with nempty_r[pop_id]=0:
  - No cmd_pass.
  - Cycle t+1: pop_rsp_vld=1, err=1, dat=0. FSM still enters WAIT.
- pop_rsp_* are registered; pop_rsp_vld is a single-cycle pulse; there is no response backpressure.
- Push when full_r=1: push_rdy=0 and the request stalls; pops continue to be served.
- flush:
  - clear=flush combinationally; no grants in a flush cycle.
  - State -> IDLE, prio -> 0.
  - A pop_rsp for a pop issued in the previous cycle still completes with the data already read.
  - Storage array contents are not cleared.
- Reset:
  - state=IDLE, prio=0, pop_rsp_vld=0, pop_rsp_id=0, pop_rsp_dat=0, pop_rsp_err=0.
  - push_rdy, pop_rdy and cmd_pass are 0 while rst is high.
  - Storage array is not reset.
  - Reset mid-operation abandons any pending response.
- Simultaneous push and pop to the same queue in one cycle is impossible: only one grant per cycle.

Test Plan:
- Ordering: push 0xA1, 0xA2, 0xA3 to id 2, then pop id 2 three times -> responses 0xA1, 0xA2, 0xA3 in order, err=0, each one cycle after its pop_rdy; then nempty_r[2]=0.
- Throughput: push_vld held high with 8 pushes -> push_rdy on every other cycle only; 8 cmd_pass pulses across 16 cycles.
- Full: fill all PTR_N=16 entries -> push_rdy stays 0 on the 17th push; a pop on id 0 is still served; the stalled push is accepted 2 cycles after that pop.
- Empty pop: pop id 3 while nempty_r[3]=0 -> pop_rsp_vld=1, err=1, dat=0 next cycle; no cmd_pass.
- Contention: push and pop both valid and eligible for 4 consecutive issue slots -> grants alternate push, pop, push, pop.
- Flush and reset: assert flush during WAIT -> clear=1, no grant that cycle, IDLE next cycle. Assert rst mid-stream -> all outputs 0 immediately, asynchronously.
